wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Shares the single register-file/PS writeback port between two producers: ALU results
//   from execute (ex_*) and load data returning from memory (mem_*).
//   - Execute results are buffered in a small FIFO. Memory returns are unbuffered and
//     have priority.
//   - A streak counter stops memory from starving execute.
//   - Sits between the execute/memory stages and the writeback_ifc consumer (regfile, PS).
// PARAMETERS
//   DEPTH       4  execute FIFO entries (power of 2, >=2)
//   MAX_STREAK  3  consecutive mem grants allowed while FIFO non-empty before ex is forced
// PORTS
//   clk           in   1   clock, all state on rising edge
//   rst           in   1   asynchronous, active-high reset
//   ex_valid      in   1   execute result offered
//   ex_ready      out  1   FIFO can accept (= !full); transfer when ex_valid & ex_ready
//   ex_reg_write  in   1   result writes a GPR
//   ex_reg_addr   in   4   GPR index
//   ex_reg_data   in   16  GPR data
//   ex_ps_write   in   1   result writes the PS (predicate/status) bit
//   ex_ps_data    in   1   PS value
//   mem_valid     in   1   load data returning
//   mem_ready     out  1   arbiter accepts load this cycle; transfer when mem_valid & mem_ready
//   mem_reg_addr  in   4   load destination GPR
//   mem_reg_data  in   16  load data
//   wb_reg_write  out  1   writeback_ifc.out reg_write (1-cycle pulse per write)
//   wb_reg_addr   out  4   writeback_ifc.out reg_addr
//   wb_reg_data   out  16  writeback_ifc.out reg_data
//   wb_ps_write   out  1   writeback_ifc.out ps_write
//   wb_ps_data    out  1   writeback_ifc.out ps_data
//   ex_count      out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   - Reset (async):
//     - FIFO emptied, pointers=0, streak=0.
//     - All wb_* outputs=0. ex_ready=1. mem_ready=1. ex_count=0.
//     - Reset mid-transfer drops all buffered results. Nothing is written after rst deasserts.
//   - Enqueue:
//     - ex transfer with ex_reg_write=0 and ex_ps_write=0 is accepted and discarded
//       (no FIFO write, no wb pulse).
//     - Enqueue is blocked only by full, never by a same-cycle dequeue.
//     - full = (ex_count==DEPTH). Pointers wrap modulo DEPTH.
//   - Grant, combinational each cycle:
//     - force_ex = fifo_nonempty & (streak==MAX_STREAK).
//     - mem_ready = !force_ex.
//     - grant_mem = mem_valid & mem_ready.
//     - grant_ex = fifo_nonempty & !grant_mem.
//   - Streak counter:
//     - streak <= 0 on grant_ex or when the FIFO is empty.
//     - Otherwise streak+1 on grant_mem, saturating at MAX_STREAK.
//     - Idle cycles hold its value.
//   - Output register: wb_* loaded every cycle from the granted source. All zeros if no grant.
//     - grant_mem -> reg_write=1, addr/data from mem_*, ps_write=0, ps_data=0.
//     - grant_ex -> FIFO head fields. Head is popped the same edge.
//   - Latency:
//     - mem transfer in cycle t -> wb pulse in cycle t+1.
//     - ex transfer in cycle t into an empty FIFO with no mem traffic -> wb pulse in cycle t+2.
//   - Ordering:
//     - Execute results retire in FIFO (program) order.
//     - mem vs ex ordering to the same GPR is not tracked here. Issue logic must not issue
//       an ex write to a GPR with a load outstanding.
//   - Simultaneous events:
//     - Enqueue+dequeue on a full FIFO: no enqueue (ex_ready was 0); the dequeue proceeds.
//     - Enqueue+dequeue on a FIFO holding 1: count stays 1; the new entry becomes head.
//   - At most one wb pulse per cycle. A GPR write and a PS write from one ex entry share
//     the same pulse.
// STRUCTURE
//   - Shared package nand_cpu_pkg:
//     - typedef struct packed {reg_write, reg_addr[3:0], reg_data[15:0], ps_write, ps_data}
//       wb_entry_t (23 bits).
//     - localparam REG_ADDR_W=4, REG_DATA_W=16.
//   - Sub-module wb_fifo #(DEPTH): sync-write/async-read circular buffer of wb_entry_t,
//     providing push, pop, head, full, empty and count.
//   - Top level: grant logic, streak counter and the output register.
// TESTING
//   1. Reset: hold rst mid-burst with 3 entries queued -> wb_* all 0, ex_count=0, ex_ready=1,
//      no wb pulse after release.
//   2. Lone ex: ex r5=0x1234 at cycle 0 -> wb_reg_write=1, addr=5, data=0x1234 at cycle 2
//      only. ex_count back to 0.
//   3. Mem priority and starvation (MAX_STREAK=3):
//      - Stimulus: FIFO holds r1; mem_valid held high with r2..r6.
//      - Required: wb order r2,r3,r4,r1,r5,r6.
//      - mem_ready=0 exactly in the r1 grant cycle.
//   4. Full (DEPTH=4), mem_valid high, MAX_STREAK=3:
//      - Stimulus: 5 back-to-back ex offers.
//      - Required: ex_ready=0 after 4 accepted; 5th accepted only after the first ex grant
//        (cycle 4); FIFO order r-values preserved.
//   5. Null/PS-only:
//      - ex with reg_write=0, ps_write=0 -> accepted, no pulse, count unchanged.
//      - ex with ps_write=1, ps_data=1 -> wb_ps_write=1, wb_ps_data=1, wb_reg_write=0.
//   6. Wrap: stream 3*DEPTH ex results with random mem interference -> all emerge in
//      order, none lost or duplicated. Scoreboard check.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : nand_cpu_pkg
// Brief  : Shared writeback types and widths for the NAND CPU datapath.
// Rev    : 1.0  initial release
// ============================================================================
package nand_cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    typedef struct packed {
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [REG_DATA_W-1:0] reg_data;
        logic                  ps_write;
        logic                  ps_data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_fifo
// Brief  : Circular buffer of writeback entries, sync write / async read head.
// Rev    : 1.0  initial release
// ============================================================================
module wb_fifo
    import nand_cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_entry_t        data_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) storage_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = storage_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter
// Brief  : Shares the writeback port between buffered ALU results and loads.
// Rev    : 1.0  initial release
// ============================================================================
module wb_arbiter
    import nand_cpu_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int MAX_STREAK = 3,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_reg_addr,
    input  logic [REG_DATA_W-1:0] ex_reg_data,
    input  logic                  ex_ps_write,
    input  logic                  ex_ps_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_reg_addr,
    input  logic [REG_DATA_W-1:0] mem_reg_data,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_reg_addr,
    output logic [REG_DATA_W-1:0] wb_reg_data,
    output logic                  wb_ps_write,
    output logic                  wb_ps_data,
    output logic [CNT_W-1:0]      ex_count
);

    localparam int                    STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_STREAK);

    wb_entry_t           w_ex_entry;
    wb_entry_t           w_head;
    wb_entry_t           wb_d;
    wb_entry_t           wb_q;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_force_ex;
    logic                w_grant_mem;
    logic                w_grant_ex;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    assign w_ex_entry = '{reg_write: ex_reg_write, reg_addr: ex_reg_addr,
                          reg_data: ex_reg_data, ps_write: ex_ps_write,
                          ps_data: ex_ps_data};

    // Results that write nothing are acknowledged but never occupy a slot.
    assign ex_ready = ~w_full;
    assign w_push   = ex_valid & ex_ready & (ex_reg_write | ex_ps_write);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_ex_entry),
        .pop_i   (w_grant_ex),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (ex_count)
    );

    assign w_force_ex  = ~w_empty & (streak_q == STREAK_MAX);
    assign mem_ready   = ~w_force_ex;
    assign w_grant_mem = mem_valid & mem_ready;
    assign w_grant_ex  = ~w_empty & ~w_grant_mem;

    always_comb begin
        streak_d = streak_q;
        if (w_grant_ex || w_empty) begin
            streak_d = '0;
        end else if (w_grant_mem && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_comb begin
        wb_d = '0;
        if (w_grant_mem) begin
            wb_d.reg_write = 1'b1;
            wb_d.reg_addr  = mem_reg_addr;
            wb_d.reg_data  = mem_reg_data;
        end else if (w_grant_ex) begin
            wb_d = w_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
            wb_q     <= '0;
        end else begin
            streak_q <= streak_d;
            wb_q     <= wb_d;
        end
    end

    assign wb_reg_write = wb_q.reg_write;
    assign wb_reg_addr  = wb_q.reg_addr;
    assign wb_reg_data  = wb_q.reg_data;
    assign wb_ps_write  = wb_q.ps_write;
    assign wb_ps_data   = wb_q.ps_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_arbiter
// Brief  : Self-checking bench: vector table, corner sequences, random stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;
    import nand_cpu_pkg::*;

    localparam int DEPTH      = 4;
    localparam int MAX_STREAK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_reg_write, ex_ps_write, ex_ps_data;
    logic [3:0]  ex_reg_addr;
    logic [15:0] ex_reg_data;
    logic        mem_valid;
    logic [3:0]  mem_reg_addr;
    logic [15:0] mem_reg_data;
    logic        ex_ready, mem_ready;
    logic        wb_reg_write, wb_ps_write, wb_ps_data;
    logic [3:0]  wb_reg_addr;
    logic [15:0] wb_reg_data;
    logic [2:0]  ex_count;

    wb_arbiter #(.DEPTH(DEPTH), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_write(ex_reg_write), .ex_reg_addr(ex_reg_addr), .ex_reg_data(ex_reg_data),
        .ex_ps_write(ex_ps_write), .ex_ps_data(ex_ps_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg_addr(mem_reg_addr), .mem_reg_data(mem_reg_data),
        .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
        .wb_ps_write(wb_ps_write), .wb_ps_data(wb_ps_data),
        .ex_count(ex_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a queue of pending results plus a count of mem grants in a row.
    wb_entry_t mq[$];
    int        mstreak;
    wb_entry_t m_wb;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        pw;
    } log_t;
    log_t wb_log[$];

    logic s_ex_ready, s_mem_ready;

    task automatic model_reset();
        mq.delete();
        mstreak = 0;
        m_wb    = '0;
    endtask

    task automatic model_step();
        bit        ne, fx, gm, ge, exr;
        wb_entry_t nxt, ent;
        ne  = (mq.size() != 0);
        fx  = ne && (mstreak == MAX_STREAK);
        gm  = (mem_valid === 1'b1) && !fx;
        ge  = ne && !gm;
        exr = (mq.size() < DEPTH);
        nxt = '0;
        if (gm) begin
            nxt.reg_write = 1'b1;
            nxt.reg_addr  = mem_reg_addr;
            nxt.reg_data  = mem_reg_data;
        end else if (ge) begin
            nxt = mq.pop_front();
        end
        if (ge || !ne) mstreak = 0;
        else if (gm && mstreak < MAX_STREAK) mstreak++;
        if (ex_valid && exr && (ex_reg_write || ex_ps_write)) begin
            ent = '{reg_write: ex_reg_write, reg_addr: ex_reg_addr, reg_data: ex_reg_data,
                    ps_write: ex_ps_write, ps_data: ex_ps_data};
            mq.push_back(ent);
        end
        m_wb = nxt;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        log_t e;
        #1;
        chk("wb_reg_write", 32'(wb_reg_write), 32'(m_wb.reg_write));
        chk("wb_reg_addr",  32'(wb_reg_addr),  32'(m_wb.reg_addr));
        chk("wb_reg_data",  32'(wb_reg_data),  32'(m_wb.reg_data));
        chk("wb_ps_write",  32'(wb_ps_write),  32'(m_wb.ps_write));
        chk("wb_ps_data",   32'(wb_ps_data),   32'(m_wb.ps_data));
        chk("ex_count",     32'(ex_count),     32'(mq.size()));
        chk("ex_ready",     32'(ex_ready),     32'(mq.size() < DEPTH));
        chk("mem_ready",    32'(mem_ready),    32'(!(mq.size() != 0 && mstreak == MAX_STREAK)));
        s_ex_ready  = ex_ready;
        s_mem_ready = mem_ready;
        if (wb_reg_write || wb_ps_write) begin
            e = '{cyc: cyc, addr: wb_reg_addr, data: wb_reg_data, pw: wb_ps_write};
            wb_log.push_back(e);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_reg_addr = '0; ex_reg_data = '0;
        ex_ps_write = 1'b0; ex_ps_data = 1'b0;
        mem_valid = 1'b0; mem_reg_addr = '0; mem_reg_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wb_log.delete();
    endtask

    typedef struct {
        logic ex_v, ex_rw; logic [3:0] ex_a; logic [15:0] ex_d; logic ex_pw, ex_pd;
        logic mem_v; logic [3:0] mem_a; logic [15:0] mem_d;
        logic e_rw; logic [3:0] e_a; logic [15:0] e_d; logic e_pw, e_pd;
        logic [2:0] e_cnt; logic e_exr, e_memr;
    } vec_t;
    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   j, k, t, low_cnt, low_cyc, r1_cyc, base, ready_at4, n_sent, nret;
        int   acc[6];
        int   exp3[6];
        bit   offer, is_null, done;
        logic [15:0] sent[$];
        logic [15:0] ret[$];
        log_t exl[$];

        // {ex v,rw,a,d,pw,pd | mem v,a,d | exp wb rw,a,d,pw,pd | cnt, ex_ready, mem_ready}
        tbl[0]  = '{1'b1,1'b1,4'd5,16'h1234,1'b0,1'b0, 1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[1]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd1,1'b1,1'b1};
        tbl[2]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b1,4'd5,16'h1234,1'b0,1'b0, 3'd0,1'b1,1'b1};
        tbl[3]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[4]  = '{1'b1,1'b0,4'd7,16'hFFFF,1'b0,1'b0, 1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[5]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[6]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[7]  = '{1'b1,1'b0,4'd0,16'h0,1'b1,1'b1,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[8]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd1,1'b1,1'b1};
        tbl[9]  = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b1,1'b1,    3'd0,1'b1,1'b1};
        tbl[10] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[11] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b1,4'd9,16'h5A5A, 1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[12] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b1,4'd9,16'h5A5A,1'b0,1'b0, 3'd0,1'b1,1'b1};
        tbl[13] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[14] = '{1'b1,1'b1,4'd2,16'h0077,1'b1,1'b0, 1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[15] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd1,1'b1,1'b1};
        tbl[16] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b1,4'd2,16'h0077,1'b1,1'b0, 3'd0,1'b1,1'b1};
        tbl[17] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[18] = '{1'b1,1'b1,4'd4,16'h0444,1'b0,1'b0, 1'b1,4'd10,16'h0AAA,1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        tbl[19] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b1,4'd10,16'h0AAA,1'b0,1'b0,3'd1,1'b1,1'b1};
        tbl[20] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b1,4'd4,16'h0444,1'b0,1'b0, 3'd0,1'b1,1'b1};
        tbl[21] = '{1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,    1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,1'b0,1'b0,    3'd0,1'b1,1'b1};
        exp3 = '{2, 3, 4, 1, 5, 6};

        // ---- Vector table: lone ex, null, PS-only, lone mem, combined, simultaneous
        do_reset();
        for (int i = 0; i < 22; i++) begin
            ex_valid = tbl[i].ex_v; ex_reg_write = tbl[i].ex_rw; ex_reg_addr = tbl[i].ex_a;
            ex_reg_data = tbl[i].ex_d; ex_ps_write = tbl[i].ex_pw; ex_ps_data = tbl[i].ex_pd;
            mem_valid = tbl[i].mem_v; mem_reg_addr = tbl[i].mem_a; mem_reg_data = tbl[i].mem_d;
            #1;
            chk($sformatf("tbl%0d_wb_reg_write", i), 32'(wb_reg_write), 32'(tbl[i].e_rw));
            chk($sformatf("tbl%0d_wb_reg_addr", i),  32'(wb_reg_addr),  32'(tbl[i].e_a));
            chk($sformatf("tbl%0d_wb_reg_data", i),  32'(wb_reg_data),  32'(tbl[i].e_d));
            chk($sformatf("tbl%0d_wb_ps_write", i),  32'(wb_ps_write),  32'(tbl[i].e_pw));
            chk($sformatf("tbl%0d_wb_ps_data", i),   32'(wb_ps_data),   32'(tbl[i].e_pd));
            chk($sformatf("tbl%0d_ex_count", i),     32'(ex_count),     32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ex_ready", i),     32'(ex_ready),     32'(tbl[i].e_exr));
            chk($sformatf("tbl%0d_mem_ready", i),    32'(mem_ready),    32'(tbl[i].e_memr));
            @(posedge clk);
            #1;
        end

        // ---- Reset mid-burst with three entries queued
        do_reset();
        for (int n = 0; n < 4; n++) begin
            mem_valid = 1'b1; mem_reg_addr = 4'(8 + n); mem_reg_data = 16'(16'h8000 + n);
            ex_valid = (n < 3); ex_reg_write = 1'b1; ex_reg_addr = 4'(1 + n);
            ex_reg_data = 16'(16'h1000 + n);
            cycle();
        end
        set_idle();
        mem_valid = 1'b1;
        #1;
        chk("rst_pre_count", 32'(ex_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_reg_addr",  32'(wb_reg_addr),  32'd0);
        chk("rst_wb_reg_data",  32'(wb_reg_data),  32'd0);
        chk("rst_wb_ps",        32'({wb_ps_write, wb_ps_data}), 32'd0);
        chk("rst_ex_count",     32'(ex_count), 32'd0);
        chk("rst_ex_ready",     32'(ex_ready), 32'd1);
        chk("rst_mem_ready",    32'(mem_ready), 32'd1);
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wb_log.delete();
        repeat (6) cycle();
        chk("rst_no_pulse_after", 32'(wb_log.size()), 32'd0);

        // ---- Mem priority and starvation relief
        do_reset();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_reg_addr = 4'd1; ex_reg_data = 16'h0101;
        cycle();
        set_idle();
        wb_log.delete();
        j = 2; low_cnt = 0; low_cyc = -1;
        for (int n = 0; n < 10; n++) begin
            mem_valid = (j <= 6); mem_reg_addr = j[3:0]; mem_reg_data = 16'(16'h0200 + j);
            t = cyc;
            cycle();
            if (!s_mem_ready) begin low_cnt++; low_cyc = t; end
            if (mem_valid && s_mem_ready) j++;
        end
        chk("prio_pulse_count", 32'(wb_log.size()), 32'd6);
        r1_cyc = -100;
        for (int i = 0; i < 6 && i < wb_log.size(); i++) begin
            chk($sformatf("prio_order%0d", i), 32'(wb_log[i].addr), 32'(exp3[i]));
            if (wb_log[i].addr == 4'd1) r1_cyc = wb_log[i].cyc;
        end
        chk("prio_mem_ready_low_count", 32'(low_cnt), 32'd1);
        chk("prio_low_in_r1_grant", 32'(low_cyc + 1), 32'(r1_cyc));

        // ---- Full FIFO under continuous mem traffic
        do_reset();
        k = 1; j = 0; base = cyc; ready_at4 = -1;
        acc = '{default: -1};
        for (int n = 0; n < 40; n++) begin
            mem_valid = 1'b1; mem_reg_addr = 4'(8 + (j % 8)); mem_reg_data = 16'(16'h8000 + j);
            ex_valid = (k <= 5); ex_reg_write = 1'b1; ex_reg_addr = 4'(k);
            ex_reg_data = 16'(16'h4000 + k); ex_ps_write = 1'b0; ex_ps_data = 1'b0;
            t = cyc - base;
            cycle();
            if (t == 4) ready_at4 = int'(s_ex_ready);
            if (ex_valid && s_ex_ready) begin acc[k] = t; k++; end
            if (s_mem_ready) j++;
        end
        set_idle();
        chk("full_ready_at4", 32'(ready_at4), 32'd0);
        chk("full_acc4_cycle", 32'(acc[4]), 32'd3);
        chk("full_acc5_cycle", 32'(acc[5]), 32'd5);
        exl.delete();
        foreach (wb_log[i]) if (wb_log[i].addr < 4'd8) exl.push_back(wb_log[i]);
        chk("full_ex_pulses", 32'(exl.size()), 32'd5);
        for (int i = 0; i < 5 && i < exl.size(); i++)
            chk($sformatf("full_order%0d", i), 32'(exl[i].data), 32'(16'h4001 + i));
        if (exl.size() > 0) chk("full_first_ex_pulse", 32'(exl[0].cyc - base), 32'd5);

        // ---- Wrap stream with random mem interference
        do_reset();
        offer = 0; is_null = 0; n_sent = 0; done = 0;
        sent.delete();
        for (int n = 0; n < 600; n++) begin
            if (!offer && n_sent < 3 * DEPTH && $urandom_range(0, 2) != 0) begin
                offer = 1;
                is_null = ($urandom_range(0, 4) == 0);
                ex_reg_write = !is_null; ex_ps_write = !is_null;
                ex_ps_data = 1'($urandom_range(0, 1));
                ex_reg_addr = 4'($urandom_range(0, 15));
                ex_reg_data = is_null ? 16'hDEAD : 16'(16'hE000 + n_sent);
            end
            ex_valid = offer;
            mem_valid = 1'($urandom_range(0, 1));
            mem_reg_addr = 4'($urandom_range(0, 15));
            mem_reg_data = 16'($urandom_range(0, 65535));
            cycle();
            if (offer && s_ex_ready) begin
                if (!is_null) begin sent.push_back(ex_reg_data); n_sent++; end
                offer = 0;
            end
            nret = 0;
            foreach (wb_log[i]) if (wb_log[i].pw) nret++;
            if (n_sent == 3 * DEPTH && !offer && nret == 3 * DEPTH) begin done = 1; break; end
        end
        set_idle();
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL wrap_timeout: retired %0d of %0d sent", nret, n_sent);
        end
        ret.delete();
        foreach (wb_log[i]) if (wb_log[i].pw) ret.push_back(wb_log[i].data);
        chk("wrap_count", 32'(ret.size()), 32'(3 * DEPTH));
        for (int i = 0; i < sent.size() && i < ret.size(); i++)
            chk($sformatf("wrap_order%0d", i), 32'(ret[i]), 32'(sent[i]));
        cycle();
        chk("wrap_drained", 32'(ex_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
